uart_frame_tx: RTL
==================

// Module: uart_frame_tx
// PURPOSE
//  Return-path UART framer: serializes 32-bit words into 8N1 UART bytes on o_tx.
//  Sends each word MSB byte first and each byte LSB bit first, the same wire format
//  the DC-DAC command receiver accepts. Groups FRAME_WORDS words into one frame and
//  reports frame completion. Sits between the status/readback logic and the PC-side TX pin.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  system clock frequency
//  BAUD         115200       UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (truncated, 868)
//  FRAME_WORDS  62           words per frame (header + 61 payload)
// PORTS
//  i_clk         in   1                   system clock
//  i_rst         in   1                   synchronous, active-high reset
//  i_word        in   32                  word to transmit
//  i_word_valid  in   1                   i_word is valid
//  o_word_ready  out  1                   word holding register empty; accept on valid&&ready
//  o_tx          out  1                   UART line, idle high
//  o_busy        out  1                   frame in progress
//  o_word_idx    out  $clog2(FRAME_WORDS) index of next word to accept within the frame
//  o_frame_done  out  1                   1-cycle pulse after the last stop bit of the frame
// BEHAVIOUR
//  Reset: o_tx=1, o_word_ready=1, o_busy=0, o_word_idx=0, o_frame_done=0.
//  Reset also clears all counters and aborts any partial byte or frame; o_tx returns high the next edge.
//  Handshake: transfer on the edge where i_word_valid && o_word_ready; i_word is sampled there.
//  One-word holding register. Ready drops on accept and rises the cycle after byte 0 (bits 7:0)
//  is handed to the byte TX, so the next word can be accepted during the last byte of the current one.
//  Latency: from an accept while the line is idle, o_tx falls (start bit) on the next edge.
//  Byte order: [31:24], [23:16], [15:8], [7:0]. Each byte is start(0), d0..d7, stop(1).
//  Each bit lasts exactly CLKS_PER_BIT cycles.
//  Bytes within a word are back-to-back with no idle gap.
//  Between words, there is no gap if the next word is already held; otherwise o_tx stays high until a word arrives.
//  Top FSM: IDLE -> SEND (4 bytes, byte counter 3..0) -> next word: SEND, or after
//  FRAME_WORDS words -> [CSUM] -> DONE (1 cycle: o_frame_done=1, o_busy=0) -> IDLE.
//  o_busy rises on the first accepted word of a frame. It falls in DONE.
//  o_word_idx increments per accepted word, saturates at FRAME_WORDS-1, and wraps to 0 in DONE.
//  o_word_ready is held 0 once all FRAME_WORDS words of a frame have been accepted, until DONE completes.
//  No timeout; a frame stalls indefinitely awaiting words.
// CONFIGURATION
//  UART_FRAME_TX_CSUM_EN defined: after the last word, one extra byte is sent in state CSUM.
//  That byte is the XOR of all 4*FRAME_WORDS data bytes, and o_frame_done follows its stop bit.
//  The accumulator clears in DONE and on reset.
//  Undefined: no CSUM state; o_frame_done follows the stop bit of the last data byte.
// STRUCTURE
//  Package uart_pkg: CLKS_PER_BIT function, typedef enum {IDLE,SEND,CSUM,DONE} frame_state_t,
//  typedef enum {B_IDLE,B_START,B_DATA,B_STOP} byte_state_t, localparams UART_DATA_BITS=8, UART_IDLE=1'b1.
//  Sub-module uart_byte_tx: i_clk, i_rst, i_data[7:0], i_valid, o_ready, o_tx.
//  It is the 8N1 bit-timing FSM using the baud counter and bit counter.
//  It raises o_ready in the last cycle of the stop bit so bytes chain with zero gap.
//  Top: holding register, byte mux, word/byte counters, checksum.
// TESTING
//  Single word 0x12345678 after reset -> line bytes 0x12,0x34,0x56,0x78 decoded LSB-first.
//    Start bit on edge after accept; each bit 868 cycles; 40 bit times total.
//  Full frame: 0x7FFFFFFF then 0x12345678, 0x9ABCDEF0, 0x00010002..0x00750076, valid always high.
//    -> 248 contiguous bytes with no idle gap; o_frame_done pulses once; o_word_idx returns to 0.
//    Loopback o_tx into uart_api_dc i_rx is required to accept the frame.
//  Valid gaps of 1000 cycles between words -> o_tx idle high during gaps.
//    Byte contents unchanged; o_busy stays 1 throughout.
//  Assert i_rst mid-bit during byte 2 of word 5 -> next edge o_tx=1, o_word_ready=1, o_word_idx=0.
//    No o_frame_done pulse; the next frame transmits correctly.
//  Backpressure: hold i_word_valid high with changing i_word -> only values present on accept edges appear on the line.
//    o_word_ready is low while the holding register is full.
//  UART_FRAME_TX_CSUM_EN with FRAME_WORDS=2, words 0x01020304, 0x10203040 -> ninth byte 0x44.
//    o_frame_done follows its stop bit.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART framer types, constants and baud divisor helper
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam logic UART_IDLE = 1'b1;
  typedef enum logic [1:0] {IDLE, SEND, CSUM, DONE} frame_state_t;
  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;
  function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
    return clk_freq_hz / baud;
  endfunction
endpackage

// File: rtl/uart_frame_tx_byte.sv
// uart_byte_tx: 8N1 byte serializer, ready in last stop cycle so bytes chain gap-free
module uart_byte_tx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [UART_DATA_BITS-1:0] i_data,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic                      o_tx
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(UART_DATA_BITS);
  byte_state_t st;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [UART_DATA_BITS-1:0] sh;
  logic bit_end;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign o_ready = st == B_IDLE || (st == B_STOP && bit_end);
  assign o_tx = st == B_START ? 1'b0 : st == B_DATA ? sh[0] : UART_IDLE;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st <= B_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
    end else if (i_valid && o_ready) begin
      st <= B_START;
      cnt <= '0;
      sh <= i_data;
    end else if (st != B_IDLE) begin
      cnt <= bit_end ? '0 : cnt + 1'b1;
      if (bit_end) begin
        if (st == B_START) begin
          st <= B_DATA;
          bit_idx <= '0;
        end else if (st == B_DATA) begin
          sh <= sh >> 1;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == BW'(UART_DATA_BITS - 1)) st <= B_STOP;
        end else begin
          st <= B_IDLE;
        end
      end
    end
  end
endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: 32-bit word to 8N1 framer, MSB byte first; UART_FRAME_TX_CSUM_EN appends an XOR checksum byte per frame
module uart_frame_tx import uart_pkg::*; #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD = 115200,
  parameter int FRAME_WORDS = 62
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [31:0]                    i_word,
  input  logic                           i_word_valid,
  output logic                           o_word_ready,
  output logic                           o_tx,
  output logic                           o_busy,
  output logic [$clog2(FRAME_WORDS)-1:0] o_word_idx,
  output logic                           o_frame_done
);
  localparam int IW = $clog2(FRAME_WORDS);
`ifdef UART_FRAME_TX_CSUM_EN
  localparam logic CSUM_EN = 1'b1;
`else
  localparam logic CSUM_EN = 1'b0;
`endif
  frame_state_t st;
  logic [31:0] hold;
  logic hold_full, last_acc, b_valid, b_ready, b_fire, w_fire, tail;
  logic [1:0] byte_cnt;
  logic [7:0] csum, b_data;
  assign tail = st == SEND && last_acc && !hold_full;
  assign b_valid = hold_full || (CSUM_EN && tail);
  assign b_data = hold_full ? hold[{byte_cnt, 3'b000} +: 8] : csum;
  assign b_fire = b_valid && b_ready;
  assign o_word_ready = !hold_full && !last_acc;
  assign w_fire = i_word_valid && o_word_ready;
  assign o_busy = st == SEND || st == CSUM;
  assign o_frame_done = st == DONE;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st <= IDLE;
      hold <= '0;
      hold_full <= 1'b0;
      last_acc <= 1'b0;
      byte_cnt <= 2'd3;
      csum <= '0;
      o_word_idx <= '0;
    end else begin
      if (w_fire) begin
        hold <= i_word;
        hold_full <= 1'b1;
        if (o_word_idx == IW'(FRAME_WORDS - 1)) last_acc <= 1'b1;
        else o_word_idx <= o_word_idx + 1'b1;
      end
      if (b_fire && hold_full) begin
        byte_cnt <= byte_cnt - 1'b1;
        csum <= csum ^ b_data;
        if (byte_cnt == 2'd0) hold_full <= 1'b0;
      end
      if (st == DONE) begin
        o_word_idx <= '0;
        last_acc <= 1'b0;
        csum <= '0;
      end
      st <= st == IDLE ? (w_fire ? SEND : IDLE) :
            st == SEND ? (tail && b_ready ? (CSUM_EN ? CSUM : DONE) : SEND) :
            st == CSUM ? (b_ready ? DONE : CSUM) : IDLE;
    end
  end
  uart_byte_tx #(.CLKS_PER_BIT(clks_per_bit(CLK_FREQ_HZ, BAUD))) u_byte (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_data(b_data),
    .i_valid(b_valid),
    .o_ready(b_ready),
    .o_tx(o_tx)
  );
endmodule
